// File: rtl/stdp_array.sv
`default_nettype none
// ============================================================================
//  Module   : stdp_array
//  Purpose  : NUM_SYN synaptic weights feeding one postsynaptic neuron, with
//             pair-based STDP applied by a serial sweep after each post spike.
//             Define STDP_LTD_EN to add depression (pre-after-post) updates.
//  Revision : 1.0 - initial release
// ============================================================================
module stdp_array #(
    parameter int                     NUM_SYN       = 8,
    parameter int                     WEIGHT_SIZE   = 16,
    parameter int                     TS_WIDTH      = 8,
    parameter int                     LEARNING_RATE = 4,
    parameter int                     WINDOW        = 8,
    parameter logic [WEIGHT_SIZE-1:0] INIT_WEIGHT   = 16'h1000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [TS_WIDTH-1:0]        time_step,
    input  logic [NUM_SYN-1:0]         spk_pre,
    input  logic                       spk_post,
    input  logic                       ld_en,
    input  logic [$clog2(NUM_SYN)-1:0] ld_addr,
    input  logic [WEIGHT_SIZE-1:0]     ld_data,
    input  logic [$clog2(NUM_SYN)-1:0] rd_addr,
    output logic [WEIGHT_SIZE-1:0]     rd_data,
    output logic                       busy,
    output logic                       update_done
);

    localparam int                c_AW   = $clog2(NUM_SYN);
    localparam logic [c_AW-1:0]   c_LAST = c_AW'(NUM_SYN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [c_AW-1:0]          r_idx;

    logic [WEIGHT_SIZE-1:0]   r_weight [NUM_SYN];
    logic [TS_WIDTH-1:0]      r_pre_ts [NUM_SYN];
    logic [NUM_SYN-1:0]       r_pre_valid;
    logic [NUM_SYN-1:0]       r_ltp_cand;
    logic [TS_WIDTH-1:0]      r_post_ts;
    logic                     r_post_seen;

    logic                     w_pending;
    logic [NUM_SYN-1:0]       w_clr;
    logic [NUM_SYN-1:0]       w_pv_kept;
    logic [NUM_SYN-1:0]       w_pv_next;
    logic [NUM_SYN-1:0]       w_cand_next;

    logic [WEIGHT_SIZE-1:0]   w_cur_w;
    logic [TS_WIDTH-1:0]      w_cur_pts;
    logic [TS_WIDTH-1:0]      w_ltp_diff;
    logic [31:0]              w_ltp_sh;
    logic                     w_ltp_en;
    logic [WEIGHT_SIZE-1:0]   w_ltp_inc;
    logic [WEIGHT_SIZE:0]     w_ltp_sum;
    logic [WEIGHT_SIZE-1:0]   w_ltp_w;
    logic [WEIGHT_SIZE-1:0]   w_new_w;

`ifdef STDP_LTD_EN
    logic [NUM_SYN-1:0]       r_ltd_pend;
    logic [NUM_SYN-1:0]       w_ltd_next;
    logic [TS_WIDTH-1:0]      w_ltd_diff;
    logic [31:0]              w_ltd_sh;
    logic                     w_ltd_en;
    logic [WEIGHT_SIZE-1:0]   w_ltd_dec;

    assign w_pending = (|r_ltp_cand) | (|r_ltd_pend);
`else
    assign w_pending = |r_ltp_cand;
`endif

    assign rd_data = r_weight[rd_addr];

    // ------------------------------------------------------------------
    // Sweep controller
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        update_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A weight load takes the cycle; the sweep starts one later.
                if (!ld_en && w_pending) begin
                    w_state_next = S_SWEEP;
                end
            end
            S_SWEEP: begin
                busy = 1'b1;
                if (r_idx == c_LAST) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                busy         = 1'b1;
                update_done  = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pending-bit bookkeeping: the sweep clear applies first, new spikes
    // recorded this cycle are layered on top so none are lost.
    // ------------------------------------------------------------------
    assign w_clr       = (r_state == S_SWEEP) ? (NUM_SYN'(1) << r_idx) : '0;
    assign w_pv_kept   = r_pre_valid & ~(w_clr & r_ltp_cand);
    assign w_pv_next   = w_pv_kept | spk_pre;
    assign w_cand_next = (r_ltp_cand & ~w_clr) | (spk_post ? w_pv_next : '0);

`ifdef STDP_LTD_EN
    assign w_ltd_next  = (r_ltd_pend & ~w_clr) |
                         ((r_post_seen && !spk_post) ? spk_pre : '0);
`endif

    // ------------------------------------------------------------------
    // Shared update datapath for the synapse under the sweep pointer
    // ------------------------------------------------------------------
    assign w_cur_w    = r_weight[r_idx];
    assign w_cur_pts  = r_pre_ts[r_idx];

    assign w_ltp_diff = r_post_ts - w_cur_pts;
    assign w_ltp_sh   = 32'(w_ltp_diff) + 32'(LEARNING_RATE);
    assign w_ltp_en   = r_ltp_cand[r_idx] && (32'(w_ltp_diff) < 32'(WINDOW));
    assign w_ltp_inc  = w_cur_w >> w_ltp_sh;
    assign w_ltp_sum  = {1'b0, w_cur_w} + {1'b0, w_ltp_inc};
    assign w_ltp_w    = !w_ltp_en             ? w_cur_w :
                        w_ltp_sum[WEIGHT_SIZE] ? '1     :
                                                 w_ltp_sum[WEIGHT_SIZE-1:0];

`ifdef STDP_LTD_EN
    assign w_ltd_diff = w_cur_pts - r_post_ts;
    assign w_ltd_sh   = 32'(w_ltd_diff) + 32'(LEARNING_RATE);
    assign w_ltd_en   = r_ltd_pend[r_idx] && (w_ltd_diff != '0) &&
                        (32'(w_ltd_diff) < 32'(WINDOW));
    // The decrement never exceeds the weight, so the floor at 0 is implicit.
    assign w_ltd_dec  = w_ltp_w >> w_ltd_sh;
    assign w_new_w    = w_ltd_en ? (w_ltp_w - w_ltd_dec) : w_ltp_w;
`else
    assign w_new_w    = w_ltp_w;
`endif

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_pre_valid <= '0;
            r_ltp_cand  <= '0;
            r_post_ts   <= '0;
            r_post_seen <= 1'b0;
`ifdef STDP_LTD_EN
            r_ltd_pend  <= '0;
`endif
            for (int i = 0; i < NUM_SYN; i++) begin
                r_weight[i] <= INIT_WEIGHT;
                r_pre_ts[i] <= '0;
            end
        end else begin
            r_state     <= w_state_next;
            r_idx       <= ((r_state == S_SWEEP) && (r_idx != c_LAST)) ?
                           r_idx + 1'b1 : '0;
            r_pre_valid <= w_pv_next;
            r_ltp_cand  <= w_cand_next;
`ifdef STDP_LTD_EN
            r_ltd_pend  <= w_ltd_next;
`endif
            for (int i = 0; i < NUM_SYN; i++) begin
                if (spk_pre[i]) begin
                    r_pre_ts[i] <= time_step;
                end
            end
            if (spk_post) begin
                r_post_ts   <= time_step;
                r_post_seen <= 1'b1;
            end
            if ((r_state == S_IDLE) && ld_en) begin
                r_weight[ld_addr] <= ld_data;
            end else if (r_state == S_SWEEP) begin
                r_weight[r_idx] <= w_new_w;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stdp_array.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stdp_array
//  Purpose  : Self-checking bench for stdp_array (directed cases + random run
//             against a behavioural model).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stdp_array;

    localparam int N   = 4;
    localparam int LR  = 4;
    localparam int WIN = 8;
    localparam int WMAX = 65535;

    logic        clk         = 1'b0;
    logic        rst         = 1'b1;
    logic [7:0]  time_step   = 8'd0;
    logic [3:0]  spk_pre     = 4'd0;
    logic        spk_post    = 1'b0;
    logic        ld_en       = 1'b0;
    logic [1:0]  ld_addr     = 2'd0;
    logic [15:0] ld_data     = 16'd0;
    logic [1:0]  rd_addr     = 2'd0;
    logic [15:0] rd_data;
    logic        busy;
    logic        update_done;

    int n_checks = 0;
    int n_errors = 0;

    stdp_array #(
        .NUM_SYN       (N),
        .WEIGHT_SIZE   (16),
        .TS_WIDTH      (8),
        .LEARNING_RATE (LR),
        .WINDOW        (WIN),
        .INIT_WEIGHT   (16'h1000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .time_step   (time_step),
        .spk_pre     (spk_pre),
        .spk_post    (spk_post),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .busy        (busy),
        .update_done (update_done)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model. m_pos: -1 idle, 0..N-1 synapse being swept, N done.
    // ------------------------------------------------------------------
    int m_w   [N];
    int m_pts [N];
    bit m_pv  [N];
    bit m_cand[N];
    bit m_ltd [N];
    int m_post_ts;
    bit m_post_seen;
    int m_pos;
    bit m_valid = 1'b0;

    always @(posedge clk or posedge rst) begin : model
        bit pend;
        bit seen_old;
        int d;
        int w;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_w[i] = 'h1000; m_pts[i] = 0; m_pv[i] = 0; m_cand[i] = 0; m_ltd[i] = 0;
            end
            m_post_ts = 0; m_post_seen = 0; m_pos = -1; m_valid = 1'b1;
        end else begin
            pend = 0;
            for (int i = 0; i < N; i++) pend = pend | m_cand[i] | m_ltd[i];
            seen_old = m_post_seen;
            if (m_pos >= 0 && m_pos < N) begin
                w = m_w[m_pos];
                if (m_cand[m_pos]) begin
                    d = (m_post_ts - m_pts[m_pos]) & 255;
                    if (d < WIN) begin
                        w = w + (w >> (d + LR));
                        if (w > WMAX) w = WMAX;
                    end
                    m_pv[m_pos] = 0;
                end
`ifdef STDP_LTD_EN
                if (m_ltd[m_pos]) begin
                    d = (m_pts[m_pos] - m_post_ts) & 255;
                    if (d >= 1 && d < WIN) w = w - (w >> (d + LR));
                end
`endif
                m_ltd[m_pos]  = 0;
                m_cand[m_pos] = 0;
                m_w[m_pos]    = w;
            end
            for (int i = 0; i < N; i++) begin
                if (spk_pre[i]) begin
                    m_pts[i] = int'(time_step);
                    m_pv[i]  = 1;
`ifdef STDP_LTD_EN
                    if (seen_old && !spk_post) m_ltd[i] = 1;
`endif
                end
            end
            if (spk_post) begin
                for (int i = 0; i < N; i++) if (m_pv[i]) m_cand[i] = 1;
                m_post_ts   = int'(time_step);
                m_post_seen = 1;
            end
            if (m_pos < 0 && ld_en) m_w[ld_addr] = int'(ld_data);
            if (m_pos < 0) begin
                if (!ld_en && pend) m_pos = 0;
            end else if (m_pos < N) begin
                m_pos = m_pos + 1;
            end else begin
                m_pos = -1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("busy",        32'(busy),        32'(m_pos >= 0));
            check("update_done", 32'(update_done), 32'(m_pos == N));
            check("rd_data",     32'(rd_data),     32'(m_w[rd_addr]));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [7:0] ts, input logic [3:0] pre, input logic post);
        time_step = ts;
        spk_pre   = pre;
        spk_post  = post;
        tick();
        spk_pre   = 4'd0;
        spk_post  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!update_done && n < 40);
        check(name, 32'(n), 32'(N + 2));
        tick();
    endtask

    task automatic read_w(input int idx, input logic [15:0] exp, input string name);
        rd_addr = 2'(idx);
        #1;
        check(name, 32'(rd_data), 32'(exp));
        tick();
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        tick();
        do_reset();

        // Reset state
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(update_done), 32'd0);
        for (int i = 0; i < N; i++) read_w(i, 16'h1000, "reset_weight");

        // Causal pair, diff 2
        step(8'd10, 4'b0001, 1'b0);
        step(8'd12, 4'b0000, 1'b1);
        wait_done("latency_ltp");
        read_w(0, 16'h1040, "ltp_w0");
        for (int i = 1; i < N; i++) read_w(i, 16'h1000, "ltp_untouched");

        // Diff equal to WINDOW: no change, pre_valid still consumed
        do_reset();
        step(8'd10, 4'b0010, 1'b0);
        step(8'd18, 4'b0000, 1'b1);
        wait_done("latency_window_edge");
        read_w(1, 16'h1000, "window_edge_w1");
        step(8'd19, 4'b0000, 1'b1);
        for (int k = 0; k < 4; k++) begin
            check("no_resweep_busy", 32'(busy), 32'd0);
            tick();
        end

        // Saturation with same-cycle pre and post
        do_reset();
        ld_en = 1'b1; ld_addr = 2'd2; ld_data = 16'hFFF0;
        tick();
        ld_en = 1'b0;
        read_w(2, 16'hFFF0, "load_w2");
        step(8'd30, 4'b0100, 1'b1);
        wait_done("latency_sat");
        read_w(2, 16'hFFFF, "sat_w2");

        // Time-step wraparound
        do_reset();
        step(8'd254, 4'b1000, 1'b0);
        step(8'd255, 4'b0000, 1'b0);
        step(8'd0,   4'b0000, 1'b0);
        step(8'd1,   4'b0000, 1'b1);
        wait_done("latency_wrap");
        read_w(3, 16'h1020, "wrap_w3");

        // Post before pre
        do_reset();
        step(8'd20, 4'b0000, 1'b1);
        step(8'd21, 4'b0000, 1'b0);
        step(8'd23, 4'b0100, 1'b0);
`ifdef STDP_LTD_EN
        wait_done("latency_ltd");
        read_w(2, 16'h0FE0, "ltd_w2");
`else
        for (int k = 0; k < 8; k++) begin
            check("ltd_off_busy", 32'(busy), 32'd0);
            tick();
        end
        read_w(2, 16'h1000, "ltd_off_w2");
`endif

        // Reset in the middle of a sweep
        do_reset();
        step(8'd40, 4'b1111, 1'b0);
        step(8'd41, 4'b0000, 1'b1);
        tick();
        tick();
        check("midsweep_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("midsweep_busy_now", 32'(busy), 32'd0);
        check("midsweep_done_now", 32'(update_done), 32'd0);
        tick();
        for (int i = 0; i < N; i++) read_w(i, 16'h1000, "midsweep_weight");
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("midsweep_no_done", 32'(update_done), 32'd0);
        end
        tick();

        // Randomised traffic against the model
        for (int k = 0; k < 3000; k++) begin
            time_step = time_step + 8'($urandom_range(0, 2));
            for (int b = 0; b < N; b++) spk_pre[b] = ($urandom_range(0, 7) == 0);
            spk_post = ($urandom_range(0, 9) == 0);
            ld_en    = ($urandom_range(0, 15) == 0);
            ld_addr  = 2'($urandom_range(0, 3));
            ld_data  = ($urandom_range(0, 3) == 0) ? (16'hFF00 | 16'($urandom_range(0, 255)))
                                                   : 16'($urandom_range(0, 65535));
            rd_addr  = 2'($urandom_range(0, 3));
            rst      = (k >= 1500 && k < 1502);
            tick();
        end
        spk_pre = 4'd0; spk_post = 1'b0; ld_en = 1'b0; rst = 1'b0;
        for (int k = 0; k < 20; k++) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
